// File: rtl/vend_change_dispenser.sv
// Coin hopper payout controller: pays a change amount in 10- and 5-unit coins.
// Optional COIN_COUNT_EN adds saturating per-coin-type payout counters.
module vend_change_dispenser #(
    parameter int AMT_W     = 8,
    parameter int PULSE_CYC = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             eject_10,
    output logic             eject_5,
    input  logic             hopper_ack,
    input  logic             hopper_empty10,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining
`ifdef COIN_COUNT_EN
    ,
    output logic [15:0]      cnt_10,
    output logic [15:0]      cnt_5
`endif
);

    localparam int PW = $clog2(PULSE_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             coin10_q, coin10_d;
    logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic             req_ready_q, req_ready_d;
    logic             eject_10_q, eject_10_d;
    logic             eject_5_q, eject_5_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             coin_acked;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin10_d    = coin10_q;
        pulse_cnt_d = pulse_cnt_q;
        timer_d     = timer_q;
        err_d       = err_q;
        coin_acked  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    remaining_d = req_amount;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    coin10_d    = (remaining_q >= AMT_W'(2)) && !hopper_empty10;
                    pulse_cnt_d = '0;
                    state_d     = S_EJECT;
                end
            end
            S_EJECT: begin
                if (pulse_cnt_q == PW'(PULSE_CYC - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                end
            end
            S_WAIT_ACK: begin
                if (hopper_ack) begin
                    coin_acked  = 1'b1;
                    remaining_d = coin10_q ? remaining_q - AMT_W'(2)
                                           : remaining_q - AMT_W'(1);
                    state_d     = S_SELECT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_DONE) && err_d;
        eject_10_d  = (state_d == S_EJECT) && coin10_d;
        eject_5_d   = (state_d == S_EJECT) && !coin10_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            coin10_q    <= 1'b0;
            pulse_cnt_q <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            eject_10_q  <= 1'b0;
            eject_5_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin10_q    <= coin10_d;
            pulse_cnt_q <= pulse_cnt_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            eject_10_q  <= eject_10_d;
            eject_5_q   <= eject_5_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign req_ready = req_ready_q;
    assign eject_10  = eject_10_q;
    assign eject_5   = eject_5_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign remaining = remaining_q;

`ifdef COIN_COUNT_EN
    logic [15:0] cnt_10_q, cnt_10_d;
    logic [15:0] cnt_5_q, cnt_5_d;

    always_comb begin
        cnt_10_d = cnt_10_q;
        cnt_5_d  = cnt_5_q;
        if (coin_acked && coin10_q && (cnt_10_q != 16'hFFFF)) begin
            cnt_10_d = cnt_10_q + 16'd1;
        end
        if (coin_acked && !coin10_q && (cnt_5_q != 16'hFFFF)) begin
            cnt_5_d = cnt_5_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_10_q <= '0;
            cnt_5_q  <= '0;
        end else begin
            cnt_10_q <= cnt_10_d;
            cnt_5_q  <= cnt_5_d;
        end
    end

    assign cnt_10 = cnt_10_q;
    assign cnt_5  = cnt_5_q;
`endif

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed self-checking bench for vend_change_dispenser (default parameters).
module tb_vend_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       eject_10;
    logic       eject_5;
    logic       hopper_ack;
    logic       hopper_empty10;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] remaining;
`ifdef COIN_COUNT_EN
    logic [15:0] cnt_10;
    logic [15:0] cnt_5;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] trace_q[$];

    always #5 clk = ~clk;

    vend_change_dispenser #(
        .AMT_W    (8),
        .PULSE_CYC(2),
        .TIMEOUT  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_amount    (req_amount),
        .req_ready     (req_ready),
        .eject_10      (eject_10),
        .eject_5       (eject_5),
        .hopper_ack    (hopper_ack),
        .hopper_empty10(hopper_empty10),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .remaining     (remaining)
`ifdef COIN_COUNT_EN
        ,
        .cnt_10        (cnt_10),
        .cnt_5         (cnt_5)
`endif
    );

    // Issues one request with req_valid held high while busy, answers each strobe
    // with a one-cycle ack right after it falls (if give_ack), and reports what it saw.
    task automatic run_pay(input logic [7:0] amt, input logic e10, input bit give_ack,
                           output int n10, output int n5, output int lat,
                           output logic [7:0] rem_done, output logic err_done,
                           output int bad_len, output int viol);
        int  len10, len5, c;
        bit  p10, p5, fin;
        n10 = 0; n5 = 0; lat = -1; rem_done = 'x; err_done = 'x;
        bad_len = 0; viol = 0; len10 = 0; len5 = 0; p10 = 0; p5 = 0; fin = 0;
        trace_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_amount = amt; hopper_empty10 = e10; hopper_ack = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_accept: got %b want 1", req_ready);
        end
        c = 0;
        while (!fin && c < 200) begin
            @(negedge clk);
            c++;
            if (c == 1) req_amount = 8'hAA;
            hopper_ack = 1'b0;
            if (c == 1 || trace_q[$] !== remaining) trace_q.push_back(remaining);
            if (req_ready !== 1'b0 || busy !== 1'b1 || remaining > amt) viol++;
            if (eject_10 && eject_5) viol++;
            if (eject_10) len10++;
            if (eject_5) len5++;
            if (p10 && !eject_10) begin n10++; if (len10 != 2) bad_len++; len10 = 0; end
            if (p5 && !eject_5) begin n5++; if (len5 != 2) bad_len++; len5 = 0; end
            if (give_ack && ((p10 && !eject_10) || (p5 && !eject_5))) hopper_ack = 1'b1;
            p10 = eject_10; p5 = eject_5;
            if (done === 1'b1) begin
                fin = 1; lat = c; rem_done = remaining; err_done = error;
                req_valid = 1'b0;
            end
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL done_timeout: no done within 200 cycles");
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || error !== 1'b0 || req_ready !== 1'b1 || remaining !== rem_done) begin
            errors++;
            $display("FAIL after_done: done=%b error=%b ready=%b rem=%0d want 0 0 1 %0d",
                     done, error, req_ready, remaining, rem_done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_amount = '0; hopper_ack = 1'b0; hopper_empty10 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
            eject_10 !== 1'b0 || eject_5 !== 1'b0 || remaining !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b err=%b e10=%b e5=%b rem=%0d want 1 0 0 0 0 0 0",
                     req_ready, busy, done, error, eject_10, eject_5, remaining);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_eject;
        int c;
        @(negedge clk);
        req_valid = 1'b1; req_amount = 8'd3; hopper_empty10 = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            c++;
        end while (eject_10 !== 1'b1 && c < 10);
        checks++;
        if (eject_10 !== 1'b1) begin
            errors++; $display("FAIL mid_eject_reach: eject_10=%b want 1", eject_10);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (eject_10 !== 1'b0 || eject_5 !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
            remaining !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_eject: e10=%b e5=%b busy=%b ready=%b rem=%0d want 0 0 0 1 0",
                     eject_10, eject_5, busy, req_ready, remaining);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || eject_10 !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b e10=%b done=%b want 0 0 0", busy, eject_10, done);
        end
    endtask

    task automatic check_run(input string nm, input int n10, input int n5, input int lat,
                             input logic [7:0] rem, input logic err, input int bad, input int viol,
                             input int e_n10, input int e_n5, input int e_lat,
                             input logic [7:0] e_rem, input logic e_err);
        checks++;
        if (n10 != e_n10 || n5 != e_n5) begin
            errors++; $display("FAIL %s_coins: n10=%0d n5=%0d want %0d %0d", nm, n10, n5, e_n10, e_n5);
        end
        checks++;
        if (lat != e_lat) begin
            errors++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, e_lat);
        end
        checks++;
        if (rem !== e_rem || err !== e_err) begin
            errors++; $display("FAIL %s_done_flags: rem=%0d err=%b want %0d %b", nm, rem, err, e_rem, e_err);
        end
        checks++;
        if (bad != 0 || viol != 0) begin
            errors++; $display("FAIL %s_protocol: bad_len=%0d viol=%0d want 0 0", nm, bad, viol);
        end
    endtask

    task automatic test_mixed_coins;
        int n10, n5, lat, bad, viol; logic [7:0] rem; logic err;
        run_pay(8'd3, 1'b0, 1'b1, n10, n5, lat, rem, err, bad, viol);
        check_run("amt3", n10, n5, lat, rem, err, bad, viol, 1, 1, 10, 8'd0, 1'b0);
    endtask

    task automatic test_empty10;
        int n10, n5, lat, bad, viol; logic [7:0] rem; logic err;
        logic [7:0] exp_tr [5];
        exp_tr = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        run_pay(8'd4, 1'b1, 1'b1, n10, n5, lat, rem, err, bad, viol);
        check_run("empty10", n10, n5, lat, rem, err, bad, viol, 0, 4, 18, 8'd0, 1'b0);
        checks++;
        if (trace_q.size() != 5) begin
            errors++; $display("FAIL empty10_trace_len: got %0d want 5", trace_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (trace_q[i] !== exp_tr[i]) begin
                    errors++; $display("FAIL empty10_trace[%0d]: got %0d want %0d", i, trace_q[i], exp_tr[i]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        int n10, n5, lat, bad, viol; logic [7:0] rem; logic err;
        run_pay(8'd2, 1'b0, 1'b0, n10, n5, lat, rem, err, bad, viol);
        check_run("timeout", n10, n5, lat, rem, err, bad, viol, 1, 0, 20, 8'd2, 1'b1);
    endtask

    task automatic test_zero_amount;
        int n10, n5, lat, bad, viol; logic [7:0] rem; logic err;
        run_pay(8'd0, 1'b0, 1'b1, n10, n5, lat, rem, err, bad, viol);
        check_run("zero", n10, n5, lat, rem, err, bad, viol, 0, 0, 2, 8'd0, 1'b0);
    endtask

`ifdef COIN_COUNT_EN
    task automatic test_coin_count;
        int n10, n5, lat, bad, viol; logic [7:0] rem; logic err;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_pay(8'd5, 1'b0, 1'b1, n10, n5, lat, rem, err, bad, viol);
        check_run("amt5", n10, n5, lat, rem, err, bad, viol, 2, 1, 14, 8'd0, 1'b0);
        checks++;
        if (cnt_10 !== 16'd2 || cnt_5 !== 16'd1) begin
            errors++; $display("FAIL coin_count: cnt_10=%0d cnt_5=%0d want 2 1", cnt_10, cnt_5);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_reset_mid_eject;
        test_mixed_coins;
        test_empty10;
        test_timeout;
        test_zero_amount;
`ifdef COIN_COUNT_EN
        test_coin_count;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
